hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register-address width.
REQ-002 SHALL have parameter MULT_LAT, default 5, HI/LO busy cycles after a mult enters E.
REQ-003 SHALL have parameter DIV_LAT, default 10, HI/LO busy cycles after a div enters E.
REQ-004 SHALL have parameter CNT_W, default 4, MDU counter width; MULT_LAT and DIV_LAT SHALL each be at most 2^CNT_W-1.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high; clears all state.
REQ-007 rs_D, rt_D  in  ADDR_W  D-stage source registers.
REQ-008 tuse_rs_D, tuse_rt_D  in  2  cycles until operand is consumed (0=D, 1=E, 2=M, 3=unused).
REQ-009 wr_en_D  in  1  D instruction writes a GPR; wr_addr_D  in  ADDR_W  destination.
REQ-010 tnew_D  in  2  cycles after E entry until the result exists (0 = PC8, 1 = ALU, 2 = load).
REQ-011 md_D  in  2  0 none, 1 mult/multu, 2 div/divu, 3 reserved (treated as none).
REQ-012 md_use_D  in  1  D instruction reads or writes HI/LO (mfhi/mflo/mthi/mtlo/mult/div).
REQ-013 stall  out  1  freeze PC and IF/ID; insert a bubble into ID/EX.
REQ-014 fwd_rs_D, fwd_rt_D  out  2  0 RF, 1 E result, 2 M result, 3 W result.
REQ-015 fwd_rs_E, fwd_rt_E  out  2  0 ID/EX value, 2 M result, 3 W result (1 unused).
REQ-016 fwd_rt_M  out  1  1 = take W result for the store data.
REQ-017 md_busy  out  1  MDU counter non-zero.

Function
REQ-018 SHALL keep slots E, M, W; each holds valid, wr_en, wr_addr, tnew, rs, rt.
REQ-019 SHALL advance every cycle: W<-M and M<-E, decrementing tnew and saturating at 0; E<-D fields with tnew=tnew_D when stall=0, else E<-bubble (valid=0).
REQ-020 SHALL treat a slot as a producer for register r only if valid, wr_en, wr_addr==r, and r!=0.
REQ-021 SHALL assert stall for an operand when the E or M producer has tnew > tuse; tuse=3 never stalls.
REQ-022 SHALL also assert stall when md_use_D=1 and (md_busy=1 or slot E holds an md start).
REQ-023 SHALL make stall the OR of the rs, rt and MDU terms; it is combinational from the D inputs and current state.
REQ-024 SHALL drive fwd_*_D by priority E, then M, then W, selecting the nearest producer only when its tnew==0; if the nearest producer has tnew>0, SHALL output 0 (stall covers the case).
REQ-025 SHALL drive fwd_*_E from slot E's rs/rt by priority M, then W, under the same tnew==0 rule, else 0.
REQ-026 SHALL set fwd_rt_M=1 iff W is a producer for slot M's rt.
REQ-027 SHALL load the MDU counter with MULT_LAT or DIV_LAT on the edge at which md_D=1 or 2 enters E unstalled; otherwise SHALL decrement it while non-zero.
REQ-028 SHALL never issue a load while the counter is non-zero, because REQ-022 blocks the issue; md_busy is high for exactly LAT cycles after the load edge.
REQ-029 SHALL ignore producers with wr_addr 0 and SHALL never stall on register 0.

Reset
REQ-030 On reset, SHALL clear all slots to valid=0, clear the counter, and clear the outputs: stall=0, all fwd_*=0, md_busy=0.
REQ-031 SHALL take effect immediately when reset is asserted mid-MDU-operation or mid-stall; the first edge after deassertion SHALL behave as an empty pipe.

Verification
REQ-032 lw $8 (tnew_D=2), then beq using $8 (tuse=0) -> stall=1 for 2 cycles, then fwd_rs_D=3.
REQ-033 addu $9 (tnew 1), then addu using $9 (tuse 1) -> stall=0; next cycle fwd_rs_E=2.
REQ-034 jal writing $31 (tnew 0), then jr $31 -> stall=0, fwd_rs_D=1.
REQ-035 mult (MULT_LAT=5), then mflo -> md_busy high for 5 cycles, stall until md_busy=0 and E holds no md start; div with DIV_LAT=10 gives 10 cycles.
REQ-036 lw $0 followed by a reader of $0 -> stall=0 and all fwd=0; asserting reset during the div busy window -> md_busy=0 at once.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Tracks the instructions sitting in the E, M and W stages of a five-stage
// pipeline. From that it decides when the instruction in D must stall, and
// which bypass path each operand should use.
//
// HI/LO (multiply/divide unit) occupancy is modelled by a down-counter.
// A mult loads MULT_LAT and a div loads DIV_LAT on the edge at which it
// enters E. Any D instruction that touches HI/LO waits until the counter
// drains.
//
// Ports
//   clk                   sole clock, rising edge
//   reset                 asynchronous, active-high; empties the pipe
//   rs_D, rt_D            D-stage source registers
//   tuse_rs_D, tuse_rt_D  cycles until the operand is consumed (3 = unused)
//   wr_en_D, wr_addr_D    D-stage destination register
//   tnew_D                cycles after E entry until the result exists
//   md_D                  0 none, 1 mult, 2 div, 3 reserved (none)
//   md_use_D              D instruction reads or writes HI/LO
//   stall                 freeze PC and IF/ID; insert a bubble into ID/EX
//   fwd_rs_D, fwd_rt_D    0 RF, 1 E result, 2 M result, 3 W result
//   fwd_rs_E, fwd_rt_E    0 ID/EX value, 2 M result, 3 W result
//   fwd_rt_M              1 = store data comes from the W result
//   md_busy               multiply/divide counter non-zero
module hazard_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_D,
    input  logic [ADDR_W-1:0] rt_D,
    input  logic [1:0]        tuse_rs_D,
    input  logic [1:0]        tuse_rt_D,
    input  logic              wr_en_D,
    input  logic [ADDR_W-1:0] wr_addr_D,
    input  logic [1:0]        tnew_D,
    input  logic [1:0]        md_D,
    input  logic              md_use_D,
    output logic              stall,
    output logic [1:0]        fwd_rs_D,
    output logic [1:0]        fwd_rt_D,
    output logic [1:0]        fwd_rs_E,
    output logic [1:0]        fwd_rt_E,
    output logic              fwd_rt_M,
    output logic              md_busy
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT);

    typedef struct packed {
        logic              valid;
        logic              wr_en;
        logic [ADDR_W-1:0] wr_addr;
        logic [1:0]        tnew;
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rt;
        logic              md_start;
    } slot_t;

    slot_t            slot_e, slot_m, slot_w;
    logic [CNT_W-1:0] md_cnt;
    logic             md_start_D;
    logic             rs_stall, rt_stall, md_stall;

    // A slot produces register r only when it really writes r.
    // Register 0 is never produced, so $0 can never cause a stall or a
    // bypass.
    function automatic logic is_prod(input slot_t s, input logic [ADDR_W-1:0] r);
        return s.valid && s.wr_en && (s.wr_addr == r) && (r != '0);
    endfunction

    function automatic logic [1:0] dec_sat(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // Both E and M are checked independently. W always has its result
    // ready in time for any tuse, so it is not checked here.
    function automatic logic op_stall(input slot_t e, input slot_t m,
                                      input logic [ADDR_W-1:0] r,
                                      input logic [1:0] tuse);
        return (tuse != 2'd3) &&
               ((is_prod(e, r) && (e.tnew > tuse)) ||
                (is_prod(m, r) && (m.tnew > tuse)));
    endfunction

    // Only the nearest producer may be used. If its value is not ready yet,
    // select the RF; the stall logic holds D until the value is ready.
    function automatic logic [1:0] fwd_d(input slot_t e, input slot_t m,
                                         input slot_t w,
                                         input logic [ADDR_W-1:0] r);
        if (is_prod(e, r))      return (e.tnew == 2'd0) ? 2'd1 : 2'd0;
        else if (is_prod(m, r)) return (m.tnew == 2'd0) ? 2'd2 : 2'd0;
        else if (is_prod(w, r)) return (w.tnew == 2'd0) ? 2'd3 : 2'd0;
        else                    return 2'd0;
    endfunction

    function automatic logic [1:0] fwd_e(input slot_t m, input slot_t w,
                                         input logic [ADDR_W-1:0] r);
        if (is_prod(m, r))      return (m.tnew == 2'd0) ? 2'd2 : 2'd0;
        else if (is_prod(w, r)) return (w.tnew == 2'd0) ? 2'd3 : 2'd0;
        else                    return 2'd0;
    endfunction

    assign md_start_D = (md_D == 2'd1) || (md_D == 2'd2);
    assign md_busy    = (md_cnt != '0);

    // The slot_e.md_start term covers the load edge itself. It only has an
    // effect if a latency parameter is ever configured as 0.
    assign rs_stall = op_stall(slot_e, slot_m, rs_D, tuse_rs_D);
    assign rt_stall = op_stall(slot_e, slot_m, rt_D, tuse_rt_D);
    assign md_stall = md_use_D && (md_busy || slot_e.md_start);
    assign stall    = rs_stall || rt_stall || md_stall;

    assign fwd_rs_D = fwd_d(slot_e, slot_m, slot_w, rs_D);
    assign fwd_rt_D = fwd_d(slot_e, slot_m, slot_w, rt_D);
    assign fwd_rs_E = fwd_e(slot_m, slot_w, slot_e.rs);
    assign fwd_rt_E = fwd_e(slot_m, slot_w, slot_e.rt);
    assign fwd_rt_M = is_prod(slot_w, slot_m.rt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_e <= '0;
            slot_m <= '0;
            slot_w <= '0;
        end else begin
            slot_w      <= slot_m;
            slot_w.tnew <= dec_sat(slot_m.tnew);
            slot_m      <= slot_e;
            slot_m.tnew <= dec_sat(slot_e.tnew);
            if (stall) begin
                slot_e <= '0;
            end else begin
                slot_e.valid    <= 1'b1;
                slot_e.wr_en    <= wr_en_D;
                slot_e.wr_addr  <= wr_addr_D;
                slot_e.tnew     <= tnew_D;
                slot_e.rs       <= rs_D;
                slot_e.rt       <= rt_D;
                slot_e.md_start <= md_start_D;
            end
        end
    end

    // A new mult/div cannot issue while the counter is non-zero, because
    // md_stall blocks it. So a load never overlaps a count in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (!stall && (md_D == 2'd1)) begin
            md_cnt <= MULT_LOAD;
        end else if (!stall && (md_D == 2'd2)) begin
            md_cnt <= DIV_LOAD;
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CNT_W'(1);
        end
    end

    // Fields carried along the pipe that no output reads.
    logic unused_fields;
    assign unused_fields = ^{slot_m.rs, slot_m.md_start,
                             slot_w.rs, slot_w.rt, slot_w.md_start};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
// Directed test of hazard_scoreboard.
//
// The reference model records, for each pipe position, which instruction
// entered E that many edges ago:
//   - A result's remaining latency is its entry tnew minus its age.
//   - HI/LO is busy until an absolute cycle number fixed at issue time.
//
// Every negedge, the model's outputs are queued and compared with the DUT.
// Directed checks pin hand-computed values.
module tb_hazard_scoreboard;

    localparam int ADDR_W   = 5;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int CNT_W    = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] rs_D, rt_D, wr_addr_D;
    logic [1:0]        tuse_rs_D, tuse_rt_D, tnew_D, md_D;
    logic              wr_en_D, md_use_D;
    logic              stall, fwd_rt_M, md_busy;
    logic [1:0]        fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1);
    end

    hazard_scoreboard #(
        .ADDR_W(ADDR_W), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D),
        .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
        .wr_en_D(wr_en_D), .wr_addr_D(wr_addr_D),
        .tnew_D(tnew_D), .md_D(md_D), .md_use_D(md_use_D),
        .stall(stall),
        .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
        .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E),
        .fwd_rt_M(fwd_rt_M), .md_busy(md_busy)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic              valid;
        logic              wr_en;
        logic [ADDR_W-1:0] wr_addr;
        logic [1:0]        tnew;
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rt;
        logic [1:0]        md;
    } rec_t;

    rec_t hist [0:2];   // hist[k] = instruction that entered E k edges ago
    int   cyc = 0;
    int   busy_until = 0;

    function automatic int rem(input int k);
        return (int'(hist[k].tnew) > k) ? int'(hist[k].tnew) - k : 0;
    endfunction

    function automatic bit prod(input int k, input logic [ADDR_W-1:0] a);
        return hist[k].valid && hist[k].wr_en && (hist[k].wr_addr == a) && (a != 0);
    endfunction

    function automatic bit op_wait(input logic [ADDR_W-1:0] a, input logic [1:0] tuse);
        if (tuse == 2'd3) return 1'b0;
        for (int k = 0; k < 2; k++)
            if (prod(k, a) && rem(k) > int'(tuse)) return 1'b1;
        return 1'b0;
    endfunction

    // Nearest producer at age >= first. Code = age + 1, or 0 if its value
    // is not ready yet.
    function automatic int src_code(input logic [ADDR_W-1:0] a, input int first);
        for (int k = first; k < 3; k++)
            if (prod(k, a)) return (rem(k) == 0) ? k + 1 : 0;
        return 0;
    endfunction

    function automatic bit m_busy();
        return cyc < busy_until;
    endfunction

    function automatic bit model_stall();
        bit md_in_e;
        md_in_e = hist[0].valid && (hist[0].md == 2'd1 || hist[0].md == 2'd2);
        return op_wait(rs_D, tuse_rs_D) || op_wait(rt_D, tuse_rt_D) ||
               (md_use_D && (m_busy() || md_in_e));
    endfunction

    function automatic rec_t d_rec();
        rec_t r;
        r.valid   = 1'b1;
        r.wr_en   = wr_en_D;
        r.wr_addr = wr_addr_D;
        r.tnew    = tnew_D;
        r.rs      = rs_D;
        r.rt      = rt_D;
        r.md      = md_D;
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist[0]    <= '0;
            hist[1]    <= '0;
            hist[2]    <= '0;
            cyc        <= 0;
            busy_until <= 0;
        end else begin
            hist[2] <= hist[1];
            hist[1] <= hist[0];
            hist[0] <= model_stall() ? rec_t'('0) : d_rec();
            cyc     <= cyc + 1;
            if (!model_stall() && (md_D == 2'd1 || md_D == 2'd2))
                busy_until <= cyc + 1 + ((md_D == 2'd1) ? MULT_LAT : DIV_LAT);
        end
    end

    // ---------------- scoreboard ----------------
    logic [10:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [10:0] e, g;
        exp_q.push_back({model_stall(), 2'(src_code(rs_D, 0)), 2'(src_code(rt_D, 0)),
                         2'(src_code(hist[0].rs, 1)), 2'(src_code(hist[0].rt, 1)),
                         prod(2, hist[1].rt), m_busy()});
        g = {stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, md_busy};
        e = exp_q.pop_front();
        chk("model_outputs", 32'(g), 32'(e));
    end

    // ---------------- driver tasks ----------------
    logic [1:0] s_fwd_rs_D, s_fwd_rt_D;

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                         input logic we, input logic [4:0] wa, input logic [1:0] tn,
                         input logic [1:0] md, input logic mu);
        rs_D = rs; rt_D = rt; tuse_rs_D = tu_rs; tuse_rt_D = tu_rt;
        wr_en_D = we; wr_addr_D = wa; tnew_D = tn; md_D = md; md_use_D = mu;
    endtask

    task automatic drive_nop();
        drive(0, 0, 3, 3, 0, 0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold an instruction in D until the model lets it issue. Count the
    // cycles the DUT asserted stall. Snapshot the D bypass selects seen in
    // the issue cycle.
    task automatic issue(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                         input logic we, input logic [4:0] wa, input logic [1:0] tn,
                         input logic [1:0] md, input logic mu, output int n_st);
        bit done;
        drive(rs, rt, tu_rs, tu_rt, we, wa, tn, md, mu);
        n_st = 0;
        done = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (stall) n_st++;
            s_fwd_rs_D = fwd_rs_D;
            s_fwd_rt_D = fwd_rt_D;
            if (!model_stall()) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) chk("issue_timeout", 1, 0);
        @(posedge clk);
        #1;
        drive_nop();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n, nb;
        bit brk;
        drive_nop();
        #2 reset = 1'b1;
        // D asks for HI/LO and a raw operand, but an empty pipe must not stall.
        drive(8, 9, 0, 0, 1, 8, 2, 1, 1);
        @(negedge clk);
        chk("reset_outputs", 32'({stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E,
                                  fwd_rt_M, md_busy}), 0);
        @(posedge clk);
        #1;
        drive_nop();
        reset = 1'b0;

        // lw $8 (tnew 2) then beq $8 (tuse 0): two stalls, then W bypass.
        issue(29, 0, 1, 3, 1, 8, 2, 0, 0, n);
        chk("lw_issue_stall", n, 0);
        issue(8, 0, 0, 0, 0, 0, 0, 0, 0, n);
        chk("load_use_stall_cycles", n, 2);
        chk("load_use_fwd_rs_D", s_fwd_rs_D, 3);
        idle(3);

        // addu $9 then addu reading $9 with tuse 1: no stall, M bypass in E.
        issue(1, 2, 1, 1, 1, 9, 1, 0, 0, n);
        issue(9, 3, 1, 1, 1, 10, 1, 0, 0, n);
        chk("alu_alu_stall_cycles", n, 0);
        chk("alu_alu_fwd_rs_D", s_fwd_rs_D, 0);
        @(negedge clk);
        chk("alu_alu_fwd_rs_E", fwd_rs_E, 2);
        chk("alu_alu_fwd_rt_E", fwd_rt_E, 0);
        idle(1);
        idle(3);

        // jal $31 (tnew 0) then jr $31 (tuse 0): E bypass, no stall.
        issue(0, 0, 3, 3, 1, 31, 0, 0, 0, n);
        issue(31, 0, 0, 3, 0, 0, 0, 0, 0, n);
        chk("jal_jr_stall_cycles", n, 0);
        chk("jal_jr_fwd_rs_D", s_fwd_rs_D, 1);
        idle(3);

        // lw $13 then addu using $13 on rt (tuse 1): one stall, then W in E.
        issue(29, 0, 1, 3, 1, 13, 2, 0, 0, n);
        issue(2, 13, 1, 1, 1, 14, 1, 0, 0, n);
        chk("load_rt_stall_cycles", n, 1);
        chk("load_rt_fwd_rt_D", s_fwd_rt_D, 0);
        @(negedge clk);
        chk("load_rt_fwd_rt_E", fwd_rt_E, 3);
        chk("load_rt_fwd_rs_E", fwd_rs_E, 0);
        idle(1);
        idle(3);

        // addu $11 then sw $11 (data tuse 2): M bypass in E, then W in M.
        issue(1, 2, 1, 1, 1, 11, 1, 0, 0, n);
        issue(29, 11, 1, 2, 0, 0, 0, 0, 0, n);
        chk("store_stall_cycles", n, 0);
        chk("store_fwd_rt_D", s_fwd_rt_D, 0);
        @(negedge clk);
        chk("store_fwd_rt_E", fwd_rt_E, 2);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("store_fwd_rt_M", fwd_rt_M, 1);
        idle(1);
        idle(3);

        // mult then mflo: mflo waits exactly MULT_LAT cycles.
        issue(4, 5, 1, 1, 0, 0, 0, 1, 1, n);
        chk("mult_issue_stall", n, 0);
        issue(0, 0, 3, 3, 1, 12, 1, 0, 1, n);
        chk("mflo_stall_cycles", n, 5);
        idle(2);

        // div: md_busy high for exactly DIV_LAT cycles.
        issue(4, 5, 1, 1, 0, 0, 0, 2, 1, n);
        chk("div_issue_stall", n, 0);
        nb = 0;
        brk = 1'b0;
        for (int k = 0; k < 40 && !brk; k++) begin
            @(negedge clk);
            if (!md_busy) brk = 1'b1;
            else begin
                nb++;
                @(posedge clk);
                #1;
            end
        end
        chk("div_busy_cycles", nb, 10);
        @(posedge clk);
        #1;
        idle(2);

        // lw $0 then a reader of $0: never stalls, never bypasses.
        issue(29, 0, 1, 3, 1, 0, 2, 0, 0, n);
        issue(0, 0, 0, 0, 1, 15, 1, 0, 0, n);
        chk("zero_stall_cycles", n, 0);
        chk("zero_fwd_rs_D", s_fwd_rs_D, 0);
        chk("zero_fwd_rt_D", s_fwd_rt_D, 0);
        @(negedge clk);
        chk("zero_fwd_rs_E", fwd_rs_E, 0);
        chk("zero_fwd_rt_E", fwd_rt_E, 0);
        idle(1);
        idle(3);

        // Reset in the middle of a div busy window, with mflo waiting in D.
        issue(4, 5, 1, 1, 0, 0, 0, 2, 1, n);
        idle(3);
        drive(0, 0, 3, 3, 1, 12, 1, 0, 1);
        #1;
        chk("div_busy_before_reset", md_busy, 1);
        chk("stall_before_reset", stall, 1);
        #1 reset = 1'b1;
        #1;
        chk("md_busy_at_reset", md_busy, 0);
        chk("stall_at_reset", stall, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        issue(0, 0, 3, 3, 1, 12, 1, 0, 1, n);
        chk("mflo_after_reset_stall", n, 0);
        issue(8, 13, 0, 0, 0, 0, 0, 0, 0, n);
        chk("reader_after_reset_stall", n, 0);
        chk("reader_after_reset_fwd_rs_D", s_fwd_rs_D, 0);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
